// File: rtl/covariance_stage_sequencer.sv
// covariance_stage_sequencer
// Top-level control for the covariance kernel. It runs three pipelined child
// loops in order through the ap_ctrl_hs handshake: the mean loop (A) once,
// the centering loop (B) once, then the covariance row loop (C) trip times.
// It also exports the current C iteration index and the cycle count of the
// last completed run.
module covariance_stage_sequencer #(
  parameter int ITER_W = 6,
  parameter int CNT_W  = 32
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [ITER_W-1:0] outer_trip,
  output logic              a_start,
  input  logic              a_ready,
  input  logic              a_done,
  output logic              b_start,
  input  logic              b_ready,
  input  logic              b_done,
  output logic              c_start,
  input  logic              c_ready,
  input  logic              c_done,
  output logic [ITER_W-1:0] c_iter,
  output logic [CNT_W-1:0]  run_cycles
);

  // GAP_C forces c_start low for one cycle when a C iteration completes in
  // its own start cycle, so consecutive C launches are always separated.
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_START_A = 4'd1,
    S_WAIT_A  = 4'd2,
    S_START_B = 4'd3,
    S_WAIT_B  = 4'd4,
    S_START_C = 4'd5,
    S_WAIT_C  = 4'd6,
    S_GAP_C   = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [ITER_W-1:0] trip_reg;
  logic [ITER_W-1:0] c_iter_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  run_cycles_reg;

  logic [CNT_W-1:0]  cnt_inc;
  logic              c_last;
  logic              c_finish;
  logic              c_step;
  logic              run_accept;

  // Saturating increment of the run counter and C-loop bookkeeping.
  always_comb begin
    cnt_inc    = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_W'(1);
    c_last     = (c_iter_reg == trip_reg - ITER_W'(1));
    c_finish   = c_done && ((state_reg == S_START_C) || (state_reg == S_WAIT_C));
    c_step     = c_finish && !c_last;
    run_accept = (state_reg == S_IDLE) && ap_start;
  end

  // State register.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. In START_x a done (with or without ready) advances
  // directly; ready alone moves to WAIT_x.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (ap_start) begin
          state_next = S_START_A;
        end
      end
      S_START_A: begin
        if (a_done) begin
          state_next = S_START_B;
        end else if (a_ready) begin
          state_next = S_WAIT_A;
        end
      end
      S_WAIT_A: begin
        if (a_done) begin
          state_next = S_START_B;
        end
      end
      S_START_B: begin
        if (b_done) begin
          state_next = (trip_reg != '0) ? S_START_C : S_DONE;
        end else if (b_ready) begin
          state_next = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (b_done) begin
          state_next = (trip_reg != '0) ? S_START_C : S_DONE;
        end
      end
      S_START_C: begin
        if (c_done) begin
          state_next = c_last ? S_DONE : S_GAP_C;
        end else if (c_ready) begin
          state_next = S_WAIT_C;
        end
      end
      S_WAIT_C: begin
        if (c_done) begin
          state_next = c_last ? S_DONE : S_START_C;
        end
      end
      S_GAP_C: begin
        state_next = S_START_C;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Outputs decoded purely from state, so at most one child start is high.
  always_comb begin
    a_start  = (state_reg == S_START_A);
    b_start  = (state_reg == S_START_B);
    c_start  = (state_reg == S_START_C);
    ap_done  = (state_reg == S_DONE);
    ap_ready = (state_reg == S_DONE);
    ap_idle  = (state_reg == S_IDLE);
  end

  // Run datapath: trip latch, iteration index, run counter and its snapshot.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      trip_reg       <= '0;
      c_iter_reg     <= '0;
      cnt_reg        <= '0;
      run_cycles_reg <= '0;
    end else begin
      if (run_accept) begin
        trip_reg   <= outer_trip;
        c_iter_reg <= '0;
        cnt_reg    <= '0;
      end else if (state_reg != S_IDLE) begin
        cnt_reg <= cnt_inc;
      end
      if (c_step) begin
        c_iter_reg <= c_iter_reg + ITER_W'(1);
      end
      // cnt_inc here includes the DONE cycle itself.
      if (state_reg == S_DONE) begin
        run_cycles_reg <= cnt_inc;
      end
    end
  end

  assign c_iter     = c_iter_reg;
  assign run_cycles = run_cycles_reg;

endmodule

// File: tb/tb_covariance_stage_sequencer.sv
// Bench for covariance_stage_sequencer: child loops are modelled with
// programmable ready/done latencies, and each run is compared against the
// expected launch order, iteration indices and an arithmetic run length.
module tb_covariance_stage_sequencer;
  localparam int ITER_W = 6;
  localparam int CNT_W  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              ap_rst = 1'b1;
  logic              ap_start = 1'b0;
  logic [ITER_W-1:0] outer_trip = '0;
  logic              ap_done, ap_idle, ap_ready;
  logic              a_start, b_start, c_start;
  logic              a_ready, a_done, b_ready, b_done, c_ready, c_done;
  logic [ITER_W-1:0] c_iter;
  logic [CNT_W-1:0]  run_cycles;

  covariance_stage_sequencer #(.ITER_W(ITER_W), .CNT_W(CNT_W)) dut (
    .ap_clk(clk), .ap_rst(ap_rst), .ap_start(ap_start),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .outer_trip(outer_trip),
    .a_start(a_start), .a_ready(a_ready), .a_done(a_done),
    .b_start(b_start), .b_ready(b_ready), .b_done(b_done),
    .c_start(c_start), .c_ready(c_ready), .c_done(c_done),
    .c_iter(c_iter), .run_cycles(run_cycles)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Child models: ready comes rdy_dly cycles after start first rises
  // (0 = same cycle), done comes done_dly cycles after ready (0 = with ready).
  int   rdy_dly[3];
  int   done_dly[3];
  int   hold_cnt[3];
  int   wait_cnt[3];
  bit   waiting[3];
  logic [2:0] st, rdy, dn;

  assign st = {c_start, b_start, a_start};

  always_comb begin
    rdy = '0;
    dn  = '0;
    for (int i = 0; i < 3; i++) begin
      rdy[i] = st[i] && (hold_cnt[i] == rdy_dly[i]);
      dn[i]  = (rdy[i] && (done_dly[i] == 0)) ||
               (waiting[i] && (wait_cnt[i] == done_dly[i]));
    end
  end

  assign a_ready = rdy[0];
  assign a_done  = dn[0];
  assign b_ready = rdy[1];
  assign b_done  = dn[1];
  assign c_ready = rdy[2];
  assign c_done  = dn[2];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ap_rst) begin
        hold_cnt[i] <= 0;
        wait_cnt[i] <= 0;
        waiting[i]  <= 1'b0;
      end else begin
        if (st[i]) begin
          if (rdy[i]) begin
            hold_cnt[i] <= 0;
            if (done_dly[i] > 0) begin
              waiting[i]  <= 1'b1;
              wait_cnt[i] <= 1;
            end
          end else begin
            hold_cnt[i] <= hold_cnt[i] + 1;
          end
        end
        if (waiting[i]) begin
          if (wait_cnt[i] == done_dly[i]) waiting[i] <= 1'b0;
          else wait_cnt[i] <= wait_cnt[i] + 1;
        end
      end
    end
  end

  // Monitor: records start launches, C indices, a_start hold lengths, done pulses.
  int ev_q[$];
  int citer_q[$];
  int a_rise_q[$];
  int done_q[$];
  int a_hold_q[$];
  int cyc = 0;
  int a_len = 0;
  logic [2:0] st_prev = '0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (ap_rst) begin
        a_len = 0;
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (st[i] && !st_prev[i]) begin
            ev_q.push_back(i);
            if (i == 2) citer_q.push_back(int'(c_iter));
            if (i == 0) a_rise_q.push_back(cyc);
          end
        end
        if (a_start) a_len++;
        else if (st_prev[0]) begin
          a_hold_q.push_back(a_len);
          a_len = 0;
        end
        if (ap_done) done_q.push_back(cyc);
        check("ready_eq_done", ap_ready, ap_done);
        check("start_exclusive", ($countones(st) <= 1), 1);
      end
      st_prev = st;
    end
  end

  task automatic clear_mon();
    ev_q.delete();
    citer_q.delete();
    a_rise_q.delete();
    done_q.delete();
    a_hold_q.delete();
  endtask

  task automatic set_delays(input int ra, rb, rc, da, db, dc);
    rdy_dly[0] = ra; rdy_dly[1] = rb; rdy_dly[2] = rc;
    done_dly[0] = da; done_dly[1] = db; done_dly[2] = dc;
  endtask

  // Expected run length from the handshake rules: each stage occupies its
  // start cycles (R+1) plus wait cycles (D); C launches completing in their
  // start cycle need one spacer cycle between them; plus the DONE cycle.
  function automatic int model_len(input int trip, ra, rb, rc, da, db, dc);
    int len;
    len = (ra + 1 + da) + (rb + 1 + db) + trip * (rc + 1 + dc) + 1;
    if (dc == 0 && trip > 1) len += trip - 1;
    return len;
  endfunction

  task automatic wait_dones(input int n);
    int budget = 0;
    while (done_q.size() < n && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 5000) check("done_timeout", 0, 1);
  endtask

  task automatic check_order(input int base, input int trip);
    for (int k = 0; k < trip + 2; k++) begin
      if (base + k < ev_q.size())
        check("ev_order", ev_q[base + k], (k < 2) ? k : 2);
    end
  endtask

  task automatic do_run(input int trip, ra, rb, rc, da, db, dc);
    set_delays(ra, rb, rc, da, db, dc);
    clear_mon();
    @(negedge clk);
    ap_start   = 1'b1;
    outer_trip = ITER_W'(trip);
    @(negedge clk);
    ap_start = 1'b0;
    wait_dones(1);
    @(negedge clk);
    check("ev_count", ev_q.size(), trip + 2);
    check_order(0, trip);
    check("c_count", citer_q.size(), trip);
    for (int k = 0; k < citer_q.size(); k++) check("c_iter_seq", citer_q[k], k);
    check("done_pulses", done_q.size(), 1);
    if (done_q.size() > 0 && a_rise_q.size() > 0)
      check("run_cycles_span", run_cycles, done_q[0] - a_rise_q[0] + 1);
    check("run_cycles_model", run_cycles, model_len(trip, ra, rb, rc, da, db, dc));
    check("a_hold", (a_hold_q.size() > 0) ? a_hold_q[0] : -1, ra + 1);
    check("c_iter_hold", c_iter, (trip == 0) ? 0 : trip - 1);
    check("idle_after", ap_idle, 1);
    $display("RUN trip=%0d rdy=%0d/%0d/%0d done=%0d/%0d/%0d run_cycles=%0d c_iter=%0d",
             trip, ra, rb, rc, da, db, dc, run_cycles, c_iter);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int budget;
    set_delays(1, 1, 1, 4, 4, 4);
    ap_rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_idle", ap_idle, 1);
    check("rst_done", ap_done, 0);
    check("rst_ready", ap_ready, 0);
    check("rst_starts", st, 0);
    check("rst_c_iter", c_iter, 0);
    check("rst_run_cycles", run_cycles, 0);
    $display("RESET idle=%0d run_cycles=%0d", ap_idle, run_cycles);
    ap_rst = 1'b0;

    do_run(3, 1, 1, 1, 4, 4, 4);
    do_run(0, 1, 1, 1, 4, 4, 4);
    do_run(3, 0, 0, 0, 0, 0, 0);
    do_run(2, 10, 1, 0, 2, 3, 1);

    // Reset during WAIT_C of the second C iteration.
    set_delays(1, 1, 1, 4, 4, 4);
    clear_mon();
    @(negedge clk);
    ap_start = 1'b1;
    outer_trip = ITER_W'(3);
    @(negedge clk);
    ap_start = 1'b0;
    budget = 0;
    while (!(c_iter == ITER_W'(1) && c_start) && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    while (c_start && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 2000) check("abort_timeout", 0, 1);
    ap_rst = 1'b1;
    @(negedge clk);
    check("abort_starts", st, 0);
    check("abort_idle", ap_idle, 1);
    check("abort_run_cycles", run_cycles, 0);
    check("abort_c_iter", c_iter, 0);
    check("abort_no_done", done_q.size(), 0);
    $display("ABORT idle=%0d run_cycles=%0d c_iter=%0d", ap_idle, run_cycles, c_iter);
    ap_rst = 1'b0;
    do_run(2, 1, 1, 1, 4, 4, 4);

    // Back-to-back runs with ap_start held across DONE; trip re-sampled.
    set_delays(0, 1, 0, 1, 0, 2);
    clear_mon();
    @(negedge clk);
    ap_start = 1'b1;
    outer_trip = ITER_W'(2);
    budget = 0;
    while (!a_start && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    outer_trip = ITER_W'(4);
    wait_dones(1);
    budget = 0;
    while (a_rise_q.size() < 2 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    ap_start = 1'b0;
    if (a_rise_q.size() >= 2 && done_q.size() >= 1)
      check("b2b_spacing", a_rise_q[1] - done_q[0], 2);
    else
      check("b2b_second_start", a_rise_q.size(), 2);
    wait_dones(2);
    @(negedge clk);
    check("b2b_ev_count", ev_q.size(), 10);
    check_order(0, 2);
    check_order(4, 4);
    check("b2b_dones", done_q.size(), 2);
    check("b2b_c_iter", c_iter, 3);
    check("b2b_run_cycles", run_cycles, model_len(4, 0, 1, 0, 1, 0, 2));
    $display("B2B run_cycles=%0d c_iter=%0d", run_cycles, c_iter);

    // Randomized runs, including the maximum trip count.
    for (int n = 0; n < 20; n++) begin
      int t, ra, rb, rc, da, db, dc;
      t  = (n == 7) ? 63 : int'($urandom_range(0, 6));
      ra = int'($urandom_range(0, 3));
      rb = int'($urandom_range(0, 3));
      rc = int'($urandom_range(0, 3));
      da = int'($urandom_range(0, 4));
      db = int'($urandom_range(0, 4));
      dc = int'($urandom_range(0, 4));
      do_run(t, ra, rb, rc, da, db, dc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/covariance_stage_sequencer.md
Name: covariance_stage_sequencer

Overview:
- Control FSM that runs the covariance kernel's three pipelined child loops in order, using the ap_ctrl_hs handshake to start each one and wait for it to finish.
- Order: mean loop (stage A) once, centering loop (stage B) once, covariance row loop (stage C) `outer_trip` times.
- Presents an ap_ctrl_hs interface upward and drives each child's ap_start.
- Exports the current iteration index and a latched total-latency count for the dataflow monitors.

Parameters:
- ITER_W, 6, width of `outer_trip` and `c_iter`.
- CNT_W, 32, width of the cycle counter `run_cycles`.

Ports:
- ap_clk  in  1  clock; the block uses this single clock only.
- ap_rst  in  1  synchronous, active-high reset.
- ap_start  in  1  top start request (level).
- ap_done  out  1  one-cycle pulse when the whole sequence completes.
- ap_idle  out  1  high while in IDLE.
- ap_ready  out  1  one-cycle pulse, coincident with ap_done.
- outer_trip  in  ITER_W  stage C trip count; sampled at the start of a run.
- a_start  out  1  ap_start to stage A.
- a_ready  in  1  ap_ready from stage A.
- a_done  in  1  ap_done from stage A.
- b_start, b_ready, b_done  out/in/in  1 each  same handshake for stage B.
- c_start, c_ready, c_done  out/in/in  1 each  same handshake for stage C.
- c_iter  out  ITER_W  index of the current stage C iteration, 0-based.
- run_cycles  out  CNT_W  cycles from leaving IDLE to DONE, latched at DONE.

Behaviour:
- Reset (synchronous, active-high):
  - state goes to IDLE.
  - Outputs: ap_done=0, ap_ready=0, all x_start=0, c_iter=0, run_cycles=0.
  - ap_idle=1 from the first cycle after reset.
  - Reset asserted mid-run aborts the run immediately. Children receive x_start=0 the next cycle; no done pulse is issued.
- States: IDLE, START_A, WAIT_A, START_B, WAIT_B, START_C, WAIT_C, DONE.
- IDLE:
  - If ap_start=1: latch `outer_trip` into trip_r, clear c_iter, clear the internal counter, go to START_A.
  - ap_start is ignored in every other state; it is re-sampled only in IDLE.
- START_x:
  - x_start=1, held until x_ready=1.
  - If x_ready=1 and x_done=0: go to WAIT_x.
  - If x_ready=1 and x_done=1 in the same cycle: skip WAIT_x and advance directly.
  - x_done without x_ready in START_x is treated as done-with-ready.
- WAIT_x:
  - x_start=0; stay until x_done=1, then advance.
- Advance order:
  - A goes to START_B.
  - B goes to START_C if trip_r!=0, else to DONE.
  - C, when done: if c_iter==trip_r-1 go to DONE; otherwise increment c_iter and return to START_C.
  - There is at least one idle cycle (x_start=0) between consecutive stage C starts.
- x_start is combinational from state (START_x only). No two x_start signals are ever high together.
- DONE:
  - ap_done=1 and ap_ready=1 for exactly one cycle.
  - run_cycles is loaded with the internal count.
  - Next state is IDLE.
  - A new run can begin in the IDLE cycle after DONE; minimum spacing between ap_done and the next a_start is 2 cycles.
- Internal counter:
  - Increments every cycle the state is not IDLE; saturates at all-ones.
  - run_cycles counts START_A through DONE inclusive.
- ap_idle=1 only in IDLE, combinational.
- c_iter:
  - Holds its value through DONE and IDLE.
  - Clears only on a new ap_start accept or on reset.
- trip_r width is ITER_W; the maximum trip count is 2^ITER_W-1.

Test Plan:
1. Reset, then ap_start=1 with outer_trip=3. Each child asserts ready 1 cycle after start and done 4 cycles after ready. Required: starts fire in order A, B, C, C, C; c_iter steps 0, 1, 2; exactly one ap_done/ap_ready pulse; run_cycles equals the measured START_A-to-DONE span.
2. outer_trip=0: required sequence A, B, then DONE; c_start never asserted; c_iter=0.
3. Child returns ready and done in the same cycle as its start acceptance. Required: WAIT state skipped; next stage START occurs on the following cycle; no double start.
4. a_ready delayed 10 cycles. Required: a_start held high continuously for 11 cycles, then low.
5. ap_rst pulsed during WAIT_C with c_iter=1. Required: all x_start=0, ap_idle=1, run_cycles=0 the next cycle; a following ap_start run completes normally.
6. ap_start held high across DONE. Required: back-to-back runs; a second a_start exactly 2 cycles after the first ap_done; outer_trip re-sampled for the second run.
